// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing the instruction-memory read port between two
// core fetch stages, with registered per-core responses, flush and perf counters.
module imem_fetch_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              flush0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              flush1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid0,
  output logic [31:0]       rsp_data0,
  output logic              rsp_valid1,
  output logic [31:0]       rsp_data1,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  stall_cnt0,
  output logic [CNT_W-1:0]  stall_cnt1
);

  logic             e0, e1;
  logic             rr_ptr_q, rr_ptr_d;
  logic             rsp_valid0_q, rsp_valid1_q;
  logic [31:0]      rsp_data0_q, rsp_data0_d;
  logic [31:0]      rsp_data1_q, rsp_data1_d;
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [CNT_W-1:0] stall_cnt0_q, stall_cnt0_d;
  logic [CNT_W-1:0] stall_cnt1_q, stall_cnt1_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    e0 = req0 & ~flush0;
    e1 = req1 & ~flush1;
    // rr_ptr names the preferred core when both request; grants masked in reset.
    gnt0 = rst & e0 & (~e1 | ~rr_ptr_q);
    gnt1 = rst & e1 & (~e0 |  rr_ptr_q);
    rr_ptr_d = (e0 && e1) ? ~rr_ptr_q : rr_ptr_q;
    mem_addr = gnt1 ? addr1 : addr0;

    rsp_data0_d = gnt0 ? mem_rd : rsp_data0_q;
    rsp_data1_d = gnt1 ? mem_rd : rsp_data1_q;

    grant_cnt0_d = sat_inc(grant_cnt0_q, gnt0);
    grant_cnt1_d = sat_inc(grant_cnt1_q, gnt1);
    stall_cnt0_d = sat_inc(stall_cnt0_q, e0 & ~gnt0);
    stall_cnt1_d = sat_inc(stall_cnt1_q, e1 & ~gnt1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q     <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt0_q <= '0;
      stall_cnt1_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid0_q <= gnt0;
      rsp_valid1_q <= gnt1;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt0_q <= stall_cnt0_d;
      stall_cnt1_q <= stall_cnt1_d;
    end
  end

  // A flush in the cycle a response is presented drops that response too.
  assign rsp_valid0 = rsp_valid0_q & ~flush0;
  assign rsp_valid1 = rsp_valid1_q & ~flush1;
  assign rsp_data0  = rsp_data0_q;
  assign rsp_data1  = rsp_data1_q;
  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt0 = stall_cnt0_q;
  assign stall_cnt1 = stall_cnt1_q;

endmodule
